traffic_request_scheduler: RTL and testbench

TRAFFIC_REQUEST_SCHEDULER -- requirements
Module: traffic_request_scheduler

---
 rtl/traffic_request_scheduler.sv | 127 ++++++++++++
 tb/tb_traffic_request_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_request_scheduler.sv
// Request scheduler sitting in front of the intersection light FSM.
// Latches vehicle sensor hits per approach and grants them round-robin once the current green has run its minimum time.
module traffic_request_scheduler #(
  parameter int WL = 10
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [7:0]    SENSE,
  input  logic [1:0]    NS,
  input  logic [1:0]    EW,
  input  logic [1:0]    NW,
  input  logic [1:0]    NE,
  input  logic [WL-1:0] MAX_GREEN,
  output logic [7:0]    NSEW,
  output logic [3:0]    PENDING,
  output logic [1:0]    SERVING,
  output logic          BUSY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] LIGHT_GREEN = 2'b10;

  state_t        state;
  logic [1:0]    ptr;
  logic [WL-1:0] hold_cnt;

  logic [1:0]    light [4];
  logic [3:0]    sense_hit;
  logic [3:0]    serving_oh;
  logic          serving_green;
  logic [3:0]    set_mask;
  logic [3:0]    clr_mask;
  logic [1:0]    winner;
  logic [WL-1:0] mg_eff;
  logic [WL-1:0] hold_limit;
  logic          hold_done;
  logic          others_waiting;

  // Index of the first requesting approach after p, wrapping back to p itself last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [7:0] code_of(input logic [1:0] i);
    return 8'h01 << {i, 1'b0};
  endfunction

  assign light[0] = NS;
  assign light[1] = EW;
  assign light[2] = NW;
  assign light[3] = NE;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment, so no latch can be inferred.
    sense_hit = '0;
    for (int i = 0; i < 4; i++) sense_hit[i] = |SENSE[2*i +: 2];
  end

  assign serving_oh    = 4'b0001 << SERVING;
  assign serving_green = (light[SERVING] == LIGHT_GREEN);

  // A car on the approach that is already green is being served, so it raises no new request.
  assign set_mask = sense_hit & ~(((state == HOLD) && serving_green) ? serving_oh : 4'b0000);
  assign clr_mask = ((state == GRANT) && serving_green) ? serving_oh : 4'b0000;

  assign winner         = rr_pick(PENDING, ptr);
  assign mg_eff         = (MAX_GREEN == '0) ? WL'(1) : MAX_GREEN;
  assign hold_limit     = mg_eff - WL'(1);
  assign hold_done      = (hold_cnt >= hold_limit);
  assign others_waiting = |(PENDING & ~serving_oh);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      NSEW     <= 8'h00;
      PENDING  <= 4'b0000;
      SERVING  <= 2'd0;
      BUSY     <= 1'b0;
      hold_cnt <= '0;
      ptr      <= 2'd3;
    end else begin
      // NOTE: non-blocking assignments so every branch below sees the pre-edge PENDING/SERVING values.
      PENDING <= (PENDING | set_mask) & ~clr_mask;
      case (state)
        IDLE: begin
          if (|PENDING) begin
            NSEW    <= code_of(winner);
            SERVING <= winner;
            BUSY    <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (serving_green) begin
            ptr      <= SERVING;
            hold_cnt <= '0;
            BUSY     <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          // ptr equals SERVING here, so the scan reaches every other approach first.
          if (hold_done && others_waiting) begin
            NSEW    <= code_of(winner);
            SERVING <= winner;
            BUSY    <= 1'b1;
            state   <= GRANT;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + WL'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_request_scheduler.sv
// Bench for traffic_request_scheduler: directed scenarios plus a randomized run,
// every cycle compared against a cycle-level reference model of the scheduling rules.
module tb_traffic_request_scheduler;

  localparam int WL = 6;

  logic          CLK;
  logic          RST_N;
  logic [7:0]    SENSE;
  logic [1:0]    NS, EW, NW, NE;
  logic [WL-1:0] MAX_GREEN;
  logic [7:0]    NSEW;
  logic [3:0]    PENDING;
  logic [1:0]    SERVING;
  logic          BUSY;

  traffic_request_scheduler #(.WL(WL)) dut (
    .CLK(CLK), .RST_N(RST_N), .SENSE(SENSE),
    .NS(NS), .EW(EW), .NW(NW), .NE(NE),
    .MAX_GREEN(MAX_GREEN),
    .NSEW(NSEW), .PENDING(PENDING), .SERVING(SERVING), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: mode 0 = idle, 1 = waiting for green, 2 = holding green.
  logic [3:0] m_pend;
  int         m_ptr, m_serv, m_mode, m_held;
  logic [7:0] m_code;
  logic       m_busy;

  // Light emulator: the granted approach turns green lt_delay cycles after its grant.
  bit         auto_lights;
  int         lt_delay;
  logic [7:0] last_code;
  int         since;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] code_for(input int i);
    return 8'(1 << (2 * i));
  endfunction

  function automatic logic [1:0] light_of(input int i);
    case (i)
      0:       return NS;
      1:       return EW;
      2:       return NW;
      default: return NE;
    endcase
  endfunction

  function automatic int pick(input logic [3:0] req, input int p);
    for (int k = 1; k <= 4; k++)
      if (req[(p + k) % 4]) return (p + k) % 4;
    return p;
  endfunction

  task automatic model_reset();
    m_pend = 4'b0000; m_ptr = 3; m_serv = 0; m_mode = 0;
    m_held = 0; m_code = 8'h00; m_busy = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] set_m, clr_m, others;
    int mg, thr, w;
    set_m = 4'b0000;
    clr_m = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (SENSE[2*i +: 2] != 2'b00 && !(m_mode == 2 && m_serv == i && light_of(i) == 2'b10))
        set_m[i] = 1'b1;
    if (m_mode == 0) begin
      if (m_pend != 4'b0000) begin
        w = pick(m_pend, m_ptr);
        m_serv = w; m_code = code_for(w); m_busy = 1'b1; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (light_of(m_serv) == 2'b10) begin
        clr_m[m_serv] = 1'b1;
        m_ptr = m_serv; m_held = 0; m_busy = 1'b0; m_mode = 2;
      end
    end else begin
      mg     = int'(MAX_GREEN);
      thr    = ((mg == 0) ? 1 : mg) - 1;
      others = m_pend & ~(4'b0001 << m_serv);
      if (m_held >= thr && others != 4'b0000) begin
        w = pick(m_pend, m_ptr);
        m_serv = w; m_code = code_for(w); m_busy = 1'b1; m_mode = 1;
      end else begin
        m_held = m_held + 1;
      end
    end
    m_pend = (m_pend | set_m) & ~clr_m;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_nsew"},    32'(NSEW),    32'(m_code));
    check({tag, "_pending"}, 32'(PENDING), 32'(m_pend));
    check({tag, "_serving"}, 32'(SERVING), 32'(m_serv));
    check({tag, "_busy"},    32'(BUSY),    32'(m_busy));
  endtask

  task automatic update_lights();
    if (auto_lights) begin
      if (NSEW != last_code) begin
        last_code = NSEW;
        since = 0;
      end else begin
        since = since + 1;
      end
      NS = (NSEW == 8'h01 && since >= lt_delay) ? 2'b10 : 2'b00;
      EW = (NSEW == 8'h04 && since >= lt_delay) ? 2'b10 : 2'b00;
      NW = (NSEW == 8'h10 && since >= lt_delay) ? 2'b10 : 2'b00;
      NE = (NSEW == 8'h40 && since >= lt_delay) ? 2'b10 : 2'b00;
    end
  endtask

  // One clock: model advances at the edge, outputs compared on the falling edge.
  task automatic tick(input string tag);
    @(posedge CLK);
    if (RST_N) model_step();
    else       model_reset();
    @(negedge CLK);
    compare_all(tag);
    update_lights();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    SENSE = 8'h00;
    NS = 2'b00; EW = 2'b00; NW = 2'b00; NE = 2'b00;
    auto_lights = 1'b0;
    last_code = 8'h00;
    since = 0;
    tick("rst");
    RST_N = 1'b1;
  endtask

  logic [7:0] order_q[$];
  int         edges;

  initial begin
    RST_N = 1'b0;
    SENSE = 8'hFF;
    NS = 2'b00; EW = 2'b00; NW = 2'b00; NE = 2'b00;
    MAX_GREEN = 6'd3;
    auto_lights = 1'b0;
    lt_delay = 2;
    last_code = 8'h00;
    since = 0;
    model_reset();

    // Reset held with every sensor active
    #1 compare_all("rst_init");
    repeat (3) tick("rst_hold");
    SENSE = 8'h00;
    RST_N = 1'b1;

    // Single EW request
    SENSE = 8'h08;
    tick("single");
    SENSE = 8'h00;
    check("single_pend", 32'(PENDING), 32'h2);
    tick("single");
    check("single_code", 32'(NSEW), 32'h04);
    check("single_busy", 32'(BUSY), 32'h1);
    repeat (3) tick("single_wait");
    EW = 2'b10;
    tick("single_green");
    check("green_pend", 32'(PENDING), 32'h0);
    check("green_busy", 32'(BUSY), 32'h0);
    check("green_code", 32'(NSEW), 32'h04);
    SENSE = 8'h08;
    repeat (2) tick("ew_on_green");
    SENSE = 8'h00;
    check("ew_on_green_pend", 32'(PENDING), 32'h0);

    // Round-robin over all four approaches
    do_reset();
    MAX_GREEN = 6'd3;
    auto_lights = 1'b1;
    lt_delay = 2;
    SENSE = 8'h55;
    tick("rr");
    SENSE = 8'h00;
    order_q.delete();
    repeat (60) begin
      tick("rr");
      if (NSEW != 8'h00 && (order_q.size() == 0 || order_q[$] != NSEW)) order_q.push_back(NSEW);
    end
    check("rr_count", 32'(order_q.size()), 32'd4);
    if (order_q.size() == 4) begin
      check("rr_first",  32'(order_q[0]), 32'h01);
      check("rr_second", 32'(order_q[1]), 32'h04);
      check("rr_third",  32'(order_q[2]), 32'h10);
      check("rr_fourth", 32'(order_q[3]), 32'h40);
    end

    // Preemption timing with MAX_GREEN=5
    do_reset();
    MAX_GREEN = 6'd5;
    SENSE = 8'h08;
    tick("pre");
    SENSE = 8'h00;
    repeat (2) tick("pre_grant");
    EW = 2'b10;
    tick("pre_hold");
    SENSE = 8'h20;
    tick("pre_hold");
    SENSE = 8'h00;
    edges = 1;
    while (NSEW != 8'h10 && edges < 20) begin
      tick("pre_hold");
      edges = edges + 1;
    end
    check("preempt_edge", 32'(edges), 32'd5);
    EW = 2'b00;

    // No competition: hold indefinitely, counter saturates
    do_reset();
    MAX_GREEN = 6'd3;
    SENSE = 8'h08;
    tick("idle_req");
    SENSE = 8'h00;
    tick("idle_grant");
    EW = 2'b10;
    tick("idle_hold");
    repeat (200) tick("long_hold");
    check("long_code", 32'(NSEW), 32'h04);
    check("long_busy", 32'(BUSY), 32'h0);
    check("long_sat",  32'(dut.hold_cnt), 32'h3F);
    MAX_GREEN = 6'h3F;
    SENSE = 8'h20;
    tick("sat_req");
    SENSE = 8'h00;
    tick("sat_preempt");
    check("sat_code", 32'(NSEW), 32'h10);
    EW = 2'b00;

    // MAX_GREEN=0 behaves as 1
    do_reset();
    MAX_GREEN = 6'd0;
    SENSE = 8'h28;
    tick("mg0");
    SENSE = 8'h00;
    tick("mg0_grant");
    check("mg0_first", 32'(NSEW), 32'h04);
    EW = 2'b10;
    tick("mg0_hold");
    tick("mg0_preempt");
    check("mg0_code", 32'(NSEW), 32'h10);
    EW = 2'b00;

    // Randomized traffic with changing MAX_GREEN and light latency
    do_reset();
    auto_lights = 1'b1;
    MAX_GREEN = 6'd2;
    lt_delay = 1;
    repeat (800) begin
      SENSE = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 15) == 0) MAX_GREEN = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) lt_delay = $urandom_range(0, 3);
      tick("rand");
    end

    // Asynchronous reset in the middle of a grant
    do_reset();
    SENSE = 8'h02;
    tick("mid");
    SENSE = 8'h00;
    tick("mid_grant");
    check("mid_busy", 32'(BUSY), 32'h1);
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge CLK);
    SENSE = 8'h40;
    RST_N = 1'b1;
    tick("post_rst");
    SENSE = 8'h00;
    check("post_rst_pend", 32'(PENDING), 32'h8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
